dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the RV32I core: the target end of the core's load/store interface. It accepts one request at a time, inserts a fixed number of wait states, and performs the access on an internal word-organised array with byte and halfword lane handling. It returns the read data or an error through a valid/ready response channel. It sits between the core's memory stage and its write-back path, replacing the zero-latency data memory so that stall and backpressure behaviour can be exercised.

## Interface
- WIDTH, 32: data and address width.
- DEPTH, 256: number of 32-bit words in the array; the legal byte address range is 0 to 4*DEPTH-1.
- WAIT, 2: wait-state cycles inserted before each access; legal range 0 to 15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_op  in  3  funct3 size code. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  WIDTH  byte address.
- req_wdata  in  WIDTH  store data; the value is right-aligned (byte in [7:0], halfword in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  WIDTH  load result, already sign- or zero-extended; 0 for stores and for errors.
- rsp_err  out  1  the request was misaligned, out of range, or used an illegal op.

## Operation
- States are IDLE, WAIT, ACCESS and RESP.
- **IDLE.** req_ready=1. When req_valid is high, the block captures write, op, addr and wdata. It then moves to WAIT and loads the counter with WAIT-1. If WAIT=0 it moves straight to ACCESS.
- **WAIT.** req_ready=0. The counter decrements each cycle. When the counter reaches 0, the block moves to ACCESS.
- **ACCESS.** The block checks the captured request and performs the access on this cycle's closing edge, then moves to RESP.
- **Error checks**, evaluated in ACCESS. Any one of these sets rsp_err=1:
  - addr[31:2] is DEPTH or greater;
  - a halfword op with addr[0]=1;
  - a word op with addr[1:0] not equal to 0;
  - a load op of 011, 110 or 111;
  - a store op of 011 or higher.
- **On error:** no array write occurs, and rsp_rdata is 0.
- **Load, byte:** the lane is selected by addr[1:0] and the result is extended per op.
- **Load, halfword:** the lane is selected by addr[1].
- **Store:** only the addressed lanes are written, via byte enables. All other bytes of the word are preserved.
- **RESP.** rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready is high at a rising edge; the block then returns to IDLE. req_valid is ignored throughout RESP.
- **Single outstanding request.** No request pipelining. A new request is accepted no earlier than the first IDLE cycle after the response handshake.
- **Reset values:** state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter 0.
- **Array contents** are not reset and are retained across reset.
- **Reset mid-operation:** the transaction is dropped with no response. A store is committed only if the ACCESS closing edge occurred before rst fell.

## Timing
- A request accepted at edge E0 produces rsp_valid=1 after edge E0+WAIT+1. With WAIT=2 that is the third edge after acceptance; with WAIT=0 it is the next edge after acceptance.
- A store becomes visible in the array at the same edge that raises rsp_valid.
- If rsp_ready is already high when rsp_valid rises, the handshake completes at the next edge: RESP lasts one cycle and the block is back in IDLE.
- Back-to-back throughput is therefore one transaction per WAIT+3 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Structure
- **Shared package:** the size codes LS_B=000, LS_H=001, LS_W=010, LS_BU=100 and LS_HU=101, plus the state encoding.
- **Sub-module dmem_lane_align.** This is purely combinational. From op, addr[1:0], the read word and the write data it produces:
  - the 4-bit byte enable;
  - the lane-shifted store word;
  - the extended load result;
  - the misalignment flag.
- The top level holds the FSM, the wait counter, the capture registers, the array and the response registers.

## Test plan
- **Word store then load.** SW 0xDEADBEEF to 0x10, then LW 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0. rsp_valid rises 3 edges after each acceptance (WAIT=2).
- **Byte lanes.** SB 0x80 to 0x13 → LW 0x10 returns 0x80ADBEEF, LB 0x13 returns 0xFFFFFF80, LBU 0x13 returns 0x00000080. Then SH 0x1234 to 0x12 → LH 0x12 returns 0x00001234.
- **Errors.** Each of the following gives rsp_err=1 and rsp_rdata=0, and the word at 0x10 is unchanged:
  - LH at 0x11;
  - SW at 0x12;
  - LW at 0x400 (DEPTH=256);
  - load op 011.
- **Backpressure.** rsp_ready held low for 5 cycles → rsp_valid, rsp_rdata and rsp_err stay stable and req_ready=0. A pulsed req_valid during this window is ignored. Raising rsp_ready brings the block back to IDLE after one edge.
- **Reset during WAIT.** Issue SW 0x0 to 0x10 and assert rst during WAIT → rsp_valid=0 and req_ready=1 immediately. After release, LW 0x10 still returns 0x1234BEEF.
- **WAIT=0 instance.** SW then LW → rsp_valid one edge after acceptance. Back-to-back requests with rsp_ready tied high are accepted every 3 cycles.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: load/store size codes,
// FSM state encoding and the op-legality helper.
package dmem_responder_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic op_legal(input logic write, input logic [2:0] op);
        if (write) begin
            return op inside {LS_B, LS_H, LS_W};
        end
        return op inside {LS_B, LS_H, LS_W, LS_BU, LS_HU};
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for a 32-bit word: byte enables and replicated
// store data, sign/zero-extended load data, and the misalignment flag.
module dmem_lane_align
    import dmem_responder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [1:0]       addr_lo,
    input  logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] wdata,
    output logic [3:0]       be,
    output logic [WIDTH-1:0] wdata_lane,
    output logic [WIDTH-1:0] rdata_ext,
    output logic             misaligned
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = 8'(rdata >> {addr_lo, 3'b000});
    assign rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // NOTE: every output gets a default before the case so that no op value
    // leaves an output unassigned, which would otherwise infer a latch.
    always_comb begin
        be         = 4'b0000;
        wdata_lane = '0;
        rdata_ext  = '0;
        misaligned = 1'b0;
        unique case (op)
            LS_B, LS_BU: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = (op == LS_B) ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            end
            LS_H, LS_HU: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = (op == LS_H) ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
                misaligned = addr_lo[0];
            end
            LS_W: begin
                be         = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rdata;
                misaligned = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, WAIT wait states, then
// an access on a word array and a registered valid/ready response.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   rd_word;
    logic [3:0]         be;
    logic [WIDTH-1:0]   st_word;
    logic [WIDTH-1:0]   ld_word;
    logic               misaligned;
    logic               range_err;
    logic               acc_err;
    logic               mem_we;

    assign idx       = addr_q[IDX_W+1:2];
    assign rd_word   = mem_q[idx];
    assign range_err = (addr_q[WIDTH-1:2] >= (WIDTH-2)'(DEPTH));
    assign acc_err   = range_err | misaligned | ~op_legal(write_q, op_q);
    assign mem_we    = (state_q == ST_ACCESS) && write_q && !acc_err;

    dmem_lane_align #(.WIDTH(WIDTH)) u_align (
        .op         (op_q),
        .addr_lo    (addr_q[1:0]),
        .rdata      (rd_word),
        .wdata      (wdata_q),
        .be         (be),
        .wdata_lane (st_word),
        .rdata_ext  (ld_word),
        .misaligned (misaligned)
    );

    // State register.
    // NOTE: sequential blocks use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (req_valid) state_d = (WAIT == 0) ? ST_ACCESS : ST_WAIT;
            ST_WAIT:   if (cnt_q == 4'd0) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decode state only; data outputs come straight from flops.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        rsp_rdata = rsp_rdata_q;
        rsp_err   = rsp_err_q;
    end

    always_comb begin
        cnt_d       = cnt_q;
        write_d     = write_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            end
            ST_ACCESS: begin
                rsp_err_d   = acc_err;
                rsp_rdata_d = (acc_err || write_q) ? '0 : ld_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            op_q        <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // NOTE: the array has no reset so its contents survive rst; a write only
    // happens from ACCESS, which reset forces the FSM out of.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx][8*i +: 8] <= st_word[8*i +: 8];
            end
        end
    end

endmodule
